// File: rtl/axi4_lite_register_bank_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the
// register bank (slave).
//   AW channel : awaddr, awvalid -> ; <- awready
//   W  channel : wdata, wstrb, wvalid -> ; <- wready
//   B  channel : <- bresp, bvalid ; bready ->
//   AR channel : araddr, arvalid -> ; <- arready
//   R  channel : <- rdata, rresp, rvalid ; rready ->
interface axi4_lite_register_bank_if #(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ADDR_WIDTH_P = 16
);
    logic [AXI_ADDR_WIDTH_P-1:0]   awaddr;
    logic                          awvalid;
    logic                          awready;
    logic [AXI_DATA_WIDTH_P-1:0]   wdata;
    logic [AXI_DATA_WIDTH_P/8-1:0] wstrb;
    logic                          wvalid;
    logic                          wready;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    logic [AXI_ADDR_WIDTH_P-1:0]   araddr;
    logic                          arvalid;
    logic                          arready;
    logic [AXI_DATA_WIDTH_P-1:0]   rdata;
    logic [1:0]                    rresp;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_register_bank.sv
// Parametrised AXI4-Lite slave register bank. Each of NR_OF_REGS_P word
// registers is RW (byte-strobed, exported on cr_registers), RO (reads return
// sr_registers) or CMD (a write pulses cmd_pulse for one cycle, reads 0).
// Unmapped, unaligned or RO-write accesses answer SLVERR.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   axi           AXI4-Lite slave side (AW/W/B/AR/R channels)
//   cr_registers  flat RW register contents, register i at [i*DATA +: DATA]
//   sr_registers  flat status inputs, only RO slices are used
//   cmd_pulse     one-cycle pulse per committed CMD register write
module axi4_lite_register_bank #(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ADDR_WIDTH_P = 16,
    parameter int NR_OF_REGS_P     = 16,
    parameter logic [NR_OF_REGS_P-1:0]                  RO_MASK_P    = '0,
    parameter logic [NR_OF_REGS_P-1:0]                  CMD_MASK_P   = '0,
    parameter logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0] RST_VALUES_P = '0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    axi4_lite_register_bank_if.slave                   axi,
    output logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0]   cr_registers,
    input  logic [NR_OF_REGS_P*AXI_DATA_WIDTH_P-1:0]   sr_registers,
    output logic [NR_OF_REGS_P-1:0]                    cmd_pulse
);
    localparam int DW       = AXI_DATA_WIDTH_P;
    localparam int AW       = AXI_ADDR_WIDTH_P;
    localparam int NR       = NR_OF_REGS_P;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int IDX_W    = 8;

    localparam logic [AW-1:0] LOW_MASK     = AW'((1 << ADDR_LSB) - 1);
    // RO takes priority if a register is flagged both RO and CMD.
    localparam logic [NR-1:0] CMD_SEL      = CMD_MASK_P & ~RO_MASK_P;
    localparam logic [NR-1:0] RW_SEL       = ~(RO_MASK_P | CMD_MASK_P);
    localparam logic [DW-1:0] ILLEGAL_DATA = DW'(32'hBAAD_FACE);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    // One-hot register select; all-zero means the address is illegal
    // (index out of range, sub-word offset, or bits set above the index field).
    function automatic logic [NR-1:0] decode(input logic [AW-1:0] addr);
        logic [NR-1:0]    sel;
        logic [IDX_W-1:0] idx;
        sel = '0;
        idx = addr[ADDR_LSB +: IDX_W];
        if ((addr & LOW_MASK) == '0 && (addr >> (ADDR_LSB + IDX_W)) == '0) begin
            for (int i = 0; i < NR; i++) begin
                if (idx == IDX_W'(i)) sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

    // Write path state
    logic          aw_full, w_full;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          bvalid_q;
    resp_e         bresp_q;
    logic [NR-1:0] cmd_pulse_q;
    logic [DW-1:0] regs_q [NR];

    // Read path state
    logic          rvalid_q;
    resp_e         rresp_q;
    logic [DW-1:0] rdata_q;

    logic          commit;
    logic [NR-1:0] wr_sel, rd_sel;
    logic [DW-1:0] rd_data_next;
    resp_e         rd_resp_next;

    assign wr_sel = decode(aw_addr_q);
    assign commit = aw_full && w_full && !bvalid_q;

    assign axi.awready = !aw_full;
    assign axi.wready  = !w_full;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = !rvalid_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = rdata_q;
    assign cmd_pulse   = cmd_pulse_q;

    for (genvar g = 0; g < NR; g++) begin : g_cr
        assign cr_registers[g*DW +: DW] = regs_q[g];
    end

    // Status inputs of non-RO registers are intentionally ignored.
    logic sr_unused;
    assign sr_unused = ^sr_registers;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; e.g. a read on the commit edge sees the old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            cmd_pulse_q <= '0;
        end else begin
            // Handshake needs an empty buffer and commit needs a full one,
            // so the two never coincide on the same buffer.
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
            if (axi.awvalid && !aw_full) begin
                aw_full   <= 1'b1;
                aw_addr_q <= axi.awaddr;
            end
            if (axi.wvalid && !w_full) begin
                w_full   <= 1'b1;
                w_data_q <= axi.wdata;
                w_strb_q <= axi.wstrb;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (|(wr_sel & (RW_SEL | CMD_SEL))) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && axi.bready) begin
                bvalid_q <= 1'b0;
            end

            cmd_pulse_q <= (commit && |w_strb_q) ? (wr_sel & CMD_SEL) : '0;
        end
    end

    // NOTE: the register array is reset like any other control state because
    // RW registers must come up at their configured values; RO/CMD entries
    // reset to zero and are never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= RW_SEL[i] ? RST_VALUES_P[i*DW +: DW] : '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NR; i++) begin
                if (wr_sel[i] && RW_SEL[i]) begin
                    for (int b = 0; b < SW; b++) begin
                        if (w_strb_q[b]) regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    always_comb begin
        rd_sel       = decode(axi.araddr);
        rd_data_next = ILLEGAL_DATA;
        rd_resp_next = RESP_SLVERR;
        for (int i = 0; i < NR; i++) begin
            if (rd_sel[i]) begin
                rd_resp_next = RESP_OKAY;
                if (RO_MASK_P[i])      rd_data_next = sr_registers[i*DW +: DW];
                else if (CMD_SEL[i])   rd_data_next = '0;
                else                   rd_data_next = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (axi.arvalid && !rvalid_q) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp_next;
            rdata_q  <= rd_data_next;
        end else if (rvalid_q && axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi4_lite_register_bank.sv
// Directed bench for axi4_lite_register_bank: 32-bit data, 16 registers,
// registers 8/9 RO, register 12 CMD, the rest RW.
module tb_axi4_lite_register_bank;
    localparam int NR      = 16;
    localparam int DW      = 32;
    localparam int AW      = 16;
    localparam int TIMEOUT = 100;
    localparam logic [NR-1:0] RO_MASK  = 16'h0300;
    localparam logic [NR-1:0] CMD_MASK = 16'h1000;

    function automatic logic [NR*DW-1:0] mk_rst();
        logic [NR*DW-1:0] r;
        r = '0;
        r[3*DW +: DW]  = 32'hDEAD_BEEF;
        r[5*DW +: DW]  = 32'h1234_5678;
        r[8*DW +: DW]  = 32'hFFFF_FFFF;   // RO: must not appear on cr_registers
        r[12*DW +: DW] = 32'h0000_00FF;   // CMD: must not appear on cr_registers
        return r;
    endfunction
    localparam logic [NR*DW-1:0] RST_VALUES = mk_rst();

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR*DW-1:0] cr_registers;
    logic [NR*DW-1:0] sr_registers;
    logic [NR-1:0]    cmd_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] exp_cr [NR];

    axi4_lite_register_bank_if #(.AXI_DATA_WIDTH_P(DW), .AXI_ADDR_WIDTH_P(AW)) axi ();

    axi4_lite_register_bank #(
        .AXI_DATA_WIDTH_P(DW),
        .AXI_ADDR_WIDTH_P(AW),
        .NR_OF_REGS_P    (NR),
        .RO_MASK_P       (RO_MASK),
        .CMD_MASK_P      (CMD_MASK),
        .RST_VALUES_P    (RST_VALUES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .axi         (axi),
        .cr_registers(cr_registers),
        .sr_registers(sr_registers),
        .cmd_pulse   (cmd_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Expected cr_registers right after reset (RO/CMD slices zero).
    task automatic init_model();
        for (int i = 0; i < NR; i++) exp_cr[i] = '0;
        exp_cr[3] = 32'hDEAD_BEEF;
        exp_cr[5] = 32'h1234_5678;
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = exp_cr[i];
        return f;
    endfunction

    function automatic logic [DW-1:0] exp_read(input int i);
        if (i == 8 || i == 9) return sr_registers[i*DW +: DW];
        if (i == 12) return '0;
        return exp_cr[i];
    endfunction

    task automatic timeout_fail(input string what);
        n_checks++;
        $display("FAIL timeout_%s: no handshake within %0d cycles", what, TIMEOUT);
    endtask

    // Present AW and/or W; returns #1 after the last handshake edge.
    task automatic send(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [3:0] strb, input bit do_aw, input bit do_w);
        bit aw_pend, w_pend, aw_hs, w_hs;
        int cyc;
        aw_pend = do_aw; w_pend = do_w; cyc = 0;
        axi.awaddr = addr; axi.awvalid = do_aw;
        axi.wdata = data; axi.wstrb = strb; axi.wvalid = do_w;
        while ((aw_pend || w_pend) && cyc < TIMEOUT) begin
            aw_hs = aw_pend && axi.awready;
            w_hs  = w_pend && axi.wready;
            @(posedge clk); #1; cyc++;
            if (aw_hs) begin aw_pend = 0; axi.awvalid = 1'b0; end
            if (w_hs)  begin w_pend = 0;  axi.wvalid = 1'b0;  end
        end
        if (aw_pend || w_pend) begin
            axi.awvalid = 1'b0; axi.wvalid = 1'b0;
            timeout_fail("aw_w");
        end
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int cyc;
        cyc = 0;
        axi.bready = 1'b1;
        while (axi.bvalid !== 1'b1 && cyc < TIMEOUT) begin
            @(posedge clk); #1; cyc++;
        end
        if (axi.bvalid !== 1'b1) begin
            resp = 2'bxx;
            timeout_fail("b");
        end else begin
            resp = axi.bresp;
            @(posedge clk); #1;
        end
        axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                            output logic [1:0] resp);
        bit hs;
        int cyc;
        hs = 0; cyc = 0;
        axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
        while (!hs && cyc < TIMEOUT) begin
            hs = axi.arready;
            @(posedge clk); #1; cyc++;
        end
        axi.arvalid = 1'b0;
        if (!hs || axi.rvalid !== 1'b1) begin
            data = 'x; resp = 2'bxx;
            timeout_fail("r");
        end else begin
            data = axi.rdata; resp = axi.rresp;
            @(posedge clk); #1;
        end
        axi.rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        logic [1:0] r;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 5'b11100)
            $display("FAIL reset_handshake: aw/w/ar ready,bvalid,rvalid=%b want 11100",
                     {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid});
        else n_pass++;
        n_checks++;
        if ({axi.bresp, axi.rresp, axi.rdata, cmd_pulse} !== '0)
            $display("FAIL reset_outputs: bresp=%b rresp=%b rdata=%h cmd_pulse=%h want 0",
                     axi.bresp, axi.rresp, axi.rdata, cmd_pulse);
        else n_pass++;
        n_checks++;
        if (cr_registers !== model_flat())
            $display("FAIL reset_cr: got %h want %h", cr_registers, model_flat());
        else n_pass++;
        for (int i = 0; i < NR; i++) begin
            axi_read(16'(i * 4), d, r);
            n_checks++;
            if ({r, d} !== {2'b00, exp_read(i)})
                $display("FAIL reset_read reg%0d: got resp=%b data=%h want resp=00 data=%h",
                         i, r, d, exp_read(i));
            else n_pass++;
        end
        axi_read(16'h0040, d, r);
        n_checks++;
        if ({r, d} !== {2'b10, 32'hBAAD_FACE})
            $display("FAIL read_idx16: got resp=%b data=%h want resp=10 data=baadface", r, d);
        else n_pass++;
    endtask

    task automatic test_w_before_aw();
        logic [DW-1:0] d;
        logic [1:0] r;
        send(16'h0, 32'hA5A5_1234, 4'b0101, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({axi.awready, axi.wready, axi.bvalid} !== 3'b100)
            $display("FAIL w_only_state: awready,wready,bvalid=%b want 100",
                     {axi.awready, axi.wready, axi.bvalid});
        else n_pass++;
        send(16'h0004, '0, 4'h0, 1'b1, 1'b0);
        wait_b(r);
        exp_cr[1] = 32'h00A5_0034;
        n_checks++;
        if (r !== 2'b00) $display("FAIL w_first_bresp: got %b want 00", r);
        else n_pass++;
        n_checks++;
        if (cr_registers !== model_flat())
            $display("FAIL w_first_cr: got %h want %h", cr_registers, model_flat());
        else n_pass++;
        axi_read(16'h0004, d, r);
        n_checks++;
        if ({r, d} !== {2'b00, 32'h00A5_0034})
            $display("FAIL w_first_read: got resp=%b data=%h want resp=00 data=00a50034", r, d);
        else n_pass++;
    endtask

    task automatic test_cmd();
        logic [DW-1:0] d;
        logic [1:0] r;
        int pulses, pulse_at, b_at, stray;
        for (int pass = 0; pass < 2; pass++) begin
            send(16'h0030, 32'hFFFF_FFFF, (pass == 0) ? 4'hF : 4'h0, 1'b1, 1'b1);
            pulses = 0; pulse_at = -1; b_at = -1; stray = 0;
            for (int k = 0; k < 5; k++) begin
                if (cmd_pulse[12] === 1'b1) begin
                    pulses++;
                    if (pulse_at < 0) pulse_at = k;
                end
                if ((cmd_pulse & ~CMD_MASK) !== '0) stray++;
                if (axi.bvalid === 1'b1 && b_at < 0) b_at = k;
                @(posedge clk); #1;
            end
            n_checks++;
            if (pass == 0 && (pulses != 1 || pulse_at != 1 || b_at != 1 || stray != 0))
                $display("FAIL cmd_pulse: count=%0d at=%0d bvalid_at=%0d stray=%0d want 1/1/1/0",
                         pulses, pulse_at, b_at, stray);
            else if (pass == 1 && (pulses != 0 || stray != 0))
                $display("FAIL cmd_no_strb: count=%0d stray=%0d want 0/0", pulses, stray);
            else n_pass++;
            wait_b(r);
            n_checks++;
            if (r !== 2'b00) $display("FAIL cmd_bresp pass%0d: got %b want 00", pass, r);
            else n_pass++;
        end
        axi_read(16'h0030, d, r);
        n_checks++;
        if ({r, d} !== {2'b00, 32'h0})
            $display("FAIL cmd_read: got resp=%b data=%h want resp=00 data=0", r, d);
        else n_pass++;
    endtask

    task automatic test_slverr();
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] d;
        logic [1:0] r;
        addrs[0] = 16'h0020;   // RO register 8
        addrs[1] = 16'h0006;   // unaligned
        addrs[2] = 16'h0040;   // index 16
        addrs[3] = 16'h0400;   // bit above index field
        for (int i = 0; i < 4; i++) begin
            send(addrs[i], 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1);
            wait_b(r);
            n_checks++;
            if (r !== 2'b10) $display("FAIL slverr_bresp addr=%h: got %b want 10", addrs[i], r);
            else n_pass++;
        end
        n_checks++;
        if (cr_registers !== model_flat())
            $display("FAIL slverr_cr: got %h want %h", cr_registers, model_flat());
        else n_pass++;
        axi_read(16'h0006, d, r);
        n_checks++;
        if ({r, d} !== {2'b10, 32'hBAAD_FACE})
            $display("FAIL unaligned_read: got resp=%b data=%h want resp=10 data=baadface", r, d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] r;
        int bad;
        send(16'h0010, 32'h1111_1111, 4'hF, 1'b1, 1'b1);
        send(16'h0018, 32'h2222_2222, 4'hF, 1'b1, 1'b1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if ({axi.bvalid, axi.bresp, axi.awready, axi.wready} !== 5'b10000) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0 || cr_registers[4*DW +: DW] !== 32'h1111_1111 || cr_registers[6*DW +: DW] !== '0)
            $display("FAIL b2b_hold: bad_cycles=%0d reg4=%h reg6=%h want 0/11111111/00000000",
                     bad, cr_registers[4*DW +: DW], cr_registers[6*DW +: DW]);
        else n_pass++;
        wait_b(r);
        n_checks++;
        if (r !== 2'b00 || axi.bvalid !== 1'b0 || cr_registers[6*DW +: DW] !== '0)
            $display("FAIL b2b_first: bresp=%b bvalid=%b reg6=%h want 00/0/00000000",
                     r, axi.bvalid, cr_registers[6*DW +: DW]);
        else n_pass++;
        wait_b(r);
        exp_cr[4] = 32'h1111_1111;
        exp_cr[6] = 32'h2222_2222;
        n_checks++;
        if (r !== 2'b00 || cr_registers !== model_flat())
            $display("FAIL b2b_second: bresp=%b cr=%h want 00 / %h", r, cr_registers, model_flat());
        else n_pass++;
    endtask

    task automatic test_same_edge_and_reset();
        logic [DW-1:0] d;
        logic [1:0] r;
        int bv, pulses;
        send(16'h0008, 32'h0000_0001, 4'hF, 1'b1, 1'b1);
        axi.araddr = 16'h0008; axi.arvalid = 1'b1; axi.rready = 1'b0;
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        n_checks++;
        if ({axi.rvalid, axi.rresp, axi.rdata, axi.bvalid, cr_registers[2*DW +: DW]}
            !== {1'b1, 2'b00, 32'h0, 1'b1, 32'h1})
            $display("FAIL same_edge: rvalid=%b rresp=%b rdata=%h bvalid=%b reg2=%h want 1/00/0/1/1",
                     axi.rvalid, axi.rresp, axi.rdata, axi.bvalid, cr_registers[2*DW +: DW]);
        else n_pass++;
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0;
        wait_b(r);
        exp_cr[2] = 32'h1;
        axi_read(16'h0008, d, r);
        n_checks++;
        if ({r, d} !== {2'b00, 32'h1})
            $display("FAIL same_edge_reread: got resp=%b data=%h want resp=00 data=1", r, d);
        else n_pass++;

        // Reset between handshake and commit of a CMD write.
        send(16'h0030, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        init_model();
        // Reset after AW only, then W alone must not complete a write.
        send(16'h0000, '0, 4'h0, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        send(16'h0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1);
        bv = 0; pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (axi.bvalid !== 1'b0) bv++;
            if (cmd_pulse !== '0) pulses++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bv != 0 || pulses != 0 || axi.awready !== 1'b1)
            $display("FAIL reset_abort: bvalid_cycles=%0d pulse_cycles=%0d awready=%b want 0/0/1",
                     bv, pulses, axi.awready);
        else n_pass++;
        n_checks++;
        if (cr_registers !== model_flat())
            $display("FAIL reset_abort_cr: got %h want %h", cr_registers, model_flat());
        else n_pass++;
    endtask

    initial begin
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        for (int i = 0; i < NR; i++) sr_registers[i*DW +: DW] = 32'h5A00_0000 | 32'(i);
        init_model();
        test_reset();
        test_w_before_aw();
        test_cmd();
        test_slverr();
        test_back_to_back();
        test_same_edge_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
